// File: rtl/board_ctrl_pkg.sv
// Shared definitions for the chess board controller: FSM state encodings,
// move-word field offsets, piece codes and a null-move helper.
package board_ctrl_pkg;

  // 3-bit controller state encodings
  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StInitIssue = 3'd1,
    StInitWait  = 3'd2,
    StMoveIssue = 3'd3,
    StMoveWait  = 3'd4,
    StDone      = 3'd5
  } state_e;

  // Move word: {piece[15:12], ox[11:9], oy[8:6], dx[5:3], dy[2:0]}
  localparam int unsigned MoveWidth  = 16;
  localparam int unsigned PieceLsb   = 12;
  localparam int unsigned PieceWidth = 4;
  localparam int unsigned OxLsb      = 9;
  localparam int unsigned OyLsb      = 6;
  localparam int unsigned DxLsb      = 3;
  localparam int unsigned DyLsb      = 0;
  localparam int unsigned CoordWidth = 3;

  // Piece codes
  localparam logic [3:0] PieceEmpty       = 4'd0;
  localparam logic [3:0] PieceBlackPawn   = 4'd1;
  localparam logic [3:0] PieceBlackKnight = 4'd2;
  localparam logic [3:0] PieceBlackBishop = 4'd3;
  localparam logic [3:0] PieceBlackRook   = 4'd4;
  localparam logic [3:0] PieceBlackQueen  = 4'd5;
  localparam logic [3:0] PieceBlackKing   = 4'd6;
  localparam logic [3:0] PieceWhitePawn   = 4'd7;
  localparam logic [3:0] PieceWhiteKnight = 4'd8;
  localparam logic [3:0] PieceWhiteBishop = 4'd9;
  localparam logic [3:0] PieceWhiteRook   = 4'd10;
  localparam logic [3:0] PieceWhiteQueen  = 4'd11;
  localparam logic [3:0] PieceWhiteKing   = 4'd12;

  // A move whose origin equals its destination is a null move
  function automatic logic is_null_move(input logic [MoveWidth-1:0] word);
    return (word[OxLsb +: CoordWidth] == word[DxLsb +: CoordWidth]) &&
           (word[OyLsb +: CoordWidth] == word[DyLsb +: CoordWidth]);
  endfunction

endpackage

// File: rtl/board_controller_if.sv
// Requester and datapath signals of the board controller. The master modport
// is the controller's view; the slave modport is the environment's view.
interface board_controller_if;
  logic        init_req;
  logic        init_ack;
  logic [1:0]  req_valid;
  logic [15:0] req0_move;
  logic [15:0] req1_move;
  logic [1:0]  req_grant;
  logic [2:0]  origin_x;
  logic [2:0]  origin_y;
  logic [2:0]  destination_x;
  logic [2:0]  destination_y;
  logic [3:0]  piece_to_move;
  logic        initialize_board;
  logic        move_piece;
  logic        initialize_complete;
  logic        move_complete;
  logic        board_ready;
  logic        turn;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  init_req, req_valid, req0_move, req1_move, initialize_complete, move_complete,
    output init_ack, req_grant, origin_x, origin_y, destination_x, destination_y,
           piece_to_move, initialize_board, move_piece, board_ready, turn, busy, done, error
  );

  modport slave (
    output init_req, req_valid, req0_move, req1_move, initialize_complete, move_complete,
    input  init_ack, req_grant, origin_x, origin_y, destination_x, destination_y,
           piece_to_move, initialize_board, move_piece, board_ready, turn, busy, done, error
  );
endinterface

// File: rtl/op_watchdog.sv
// Operation watchdog: counts enabled cycles from a clear and flags expiry when
// the count reaches Limit-1. The count saturates there instead of wrapping.
module op_watchdog #(
  parameter int unsigned     Width = 16,
  parameter logic [Width-1:0] Limit = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [Width-1:0] count_q, count_d;
  logic             at_limit;

  assign at_limit = (count_q == Limit - 1'b1);
  assign expire   = enable & at_limit;

  // Next count: clear wins over enable; hold once the limit is reached
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !at_limit) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/board_controller.sv
// Chess board controller: arbitrates init and move requests between white (0)
// and black (1), enforces turn order, holds the move word for the datapath and
// reports done/error. Define BOARD_CTRL_TIMEOUT_EN to build the watchdog and
// timeout path; without it the WAIT states wait indefinitely.
module board_controller
  import board_ctrl_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096,
  parameter bit          STRICT_TURNS   = 1'b1
) (
  input logic                clk,
  input logic                reset,
  board_controller_if.master bus
);

  state_e                 state_q, state_d;
  logic [MoveWidth-1:0]   move_q;
  logic [MoveWidth-1:0]   sel_word;
  logic                   sel;
  logic                   op_init_q;
  logic                   board_ready_q;
  logic                   turn_q;
  logic                   accept_init;
  logic                   accept_move;
  logic [1:0]             grant;
  logic                   reject;
  logic                   timeout;
  logic                   expire;

`ifdef BOARD_CTRL_TIMEOUT_EN
  logic wd_clear;
  logic wd_enable;

  assign wd_clear  = (state_q == StInitIssue) || (state_q == StMoveIssue);
  assign wd_enable = (state_q == StInitWait) || (state_q == StMoveWait);

  op_watchdog #(
    .Width (16),
    .Limit (TIMEOUT_CYCLES)
  ) u_op_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (expire)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif

  // Arbitration and next-state logic
  always_comb begin
    state_d     = state_q;
    accept_init = 1'b0;
    accept_move = 1'b0;
    grant       = 2'b00;
    reject      = 1'b0;
    timeout     = 1'b0;
    // Turn holder first; the other side only when turns are relaxed and the
    // holder is not requesting.
    sel = turn_q;
    if (!STRICT_TURNS && !bus.req_valid[turn_q]) begin
      sel = ~turn_q;
    end
    sel_word = sel ? bus.req1_move : bus.req0_move;

    unique case (state_q)
      StIdle: begin
        if (bus.init_req) begin
          accept_init = 1'b1;
          state_d     = StInitIssue;
        end else if (board_ready_q && bus.req_valid[sel]) begin
          accept_move = 1'b1;
          grant       = sel ? 2'b10 : 2'b01;
          if (is_null_move(sel_word)) begin
            reject = 1'b1;
          end else begin
            state_d = StMoveIssue;
          end
        end
      end
      StInitIssue: state_d = StInitWait;
      StInitWait: begin
        // Completion wins over a same-cycle expiry
        if (bus.initialize_complete) begin
          state_d = StDone;
        end else if (expire) begin
          timeout = 1'b1;
          state_d = StIdle;
        end
      end
      StMoveIssue: state_d = StMoveWait;
      StMoveWait: begin
        if (bus.move_complete) begin
          state_d = StDone;
        end else if (expire) begin
          timeout = 1'b1;
          state_d = StIdle;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Accepted move word; held unchanged until the next acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      move_q <= '0;
    end else if (accept_move) begin
      move_q <= sel_word;
    end
  end

  // Operation kind, used by DONE to decide between init and move bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_init_q <= 1'b0;
    end else if (accept_init) begin
      op_init_q <= 1'b1;
    end else if (accept_move) begin
      op_init_q <= 1'b0;
    end
  end

  // Board status and turn bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board_ready_q <= 1'b0;
      turn_q        <= 1'b0;
    end else if (timeout) begin
      board_ready_q <= 1'b0;
    end else if (state_q == StDone) begin
      if (op_init_q) begin
        board_ready_q <= 1'b1;
        turn_q        <= 1'b0;
      end else begin
        turn_q <= ~turn_q;
      end
    end
  end

  // Mealy pulses are masked during reset so every output reads 0 then
  assign bus.init_ack         = accept_init & ~reset;
  assign bus.req_grant        = grant & {2{~reset}};
  assign bus.error            = (reject | timeout) & ~reset;
  assign bus.initialize_board = (state_q == StInitIssue);
  assign bus.move_piece       = (state_q == StMoveIssue);
  assign bus.busy             = (state_q != StIdle);
  assign bus.done             = (state_q == StDone);
  assign bus.board_ready      = board_ready_q;
  assign bus.turn             = turn_q;
  assign bus.piece_to_move    = move_q[PieceLsb +: PieceWidth];
  assign bus.origin_x         = move_q[OxLsb +: CoordWidth];
  assign bus.origin_y         = move_q[OyLsb +: CoordWidth];
  assign bus.destination_x    = move_q[DxLsb +: CoordWidth];
  assign bus.destination_y    = move_q[DyLsb +: CoordWidth];

endmodule

// File: doc/board_controller.md
# board_controller

Sequencing and arbitration controller for the chess board datapath. It accepts board-initialise requests and move requests from two requesters: requester 0 is white and requester 1 is black. It enforces turn order, latches one operation at a time and drives the datapath's `initialize_board` and `move_piece` handshake. It also holds coordinates stable for the whole operation and reports completion or failure to the game logic.

## Interface
- `TIMEOUT_CYCLES`, default 16'd4096: watchdog limit per datapath operation, in clk cycles.
- `STRICT_TURNS`, default 1: 1 grants a move only to the requester whose turn it is; 0 lets the non-turn requester go when the turn holder is idle.

Ports:
- `clk` input 1: single system clock.
- `reset` input 1: asynchronous, active-high reset.
- `init_req` input 1: level request to (re)initialise the board.
- `init_ack` output 1: one-cycle pulse when the init request is accepted.
- `req_valid` input 2: per-requester move request, level.
- `req0_move` input 16: `{piece[15:12], ox[11:9], oy[8:6], dx[5:3], dy[2:0]}`.
- `req1_move` input 16: same packing as `req0_move`.
- `req_grant` output 2: one-hot one-cycle pulse when a move is accepted.
- `origin_x`, `origin_y`, `destination_x`, `destination_y` output 3 each: move coordinates to the datapath.
- `piece_to_move` output 4: piece code to the datapath.
- `initialize_board` output 1: one-cycle start pulse to the datapath.
- `move_piece` output 1: one-cycle start pulse to the datapath.
- `initialize_complete` input 1: datapath done pulse.
- `move_complete` input 1: datapath done pulse.
- `board_ready` output 1: board initialised and no fault since.
- `turn` output 1: 0 = white, 1 = black.
- `busy` output 1: controller is not in IDLE.
- `done` output 1: one-cycle pulse when an operation completes.
- `error` output 1: one-cycle pulse on a rejected move or a timeout.

## Operation
States and transitions:
- IDLE: arbitrates the inputs and moves to INIT_ISSUE or MOVE_ISSUE.
- INIT_ISSUE: moves to INIT_WAIT.
- INIT_WAIT: moves to DONE on completion, or to IDLE on timeout.
- MOVE_ISSUE: moves to MOVE_WAIT.
- MOVE_WAIT: moves to DONE on completion, or to IDLE on timeout.
- DONE: moves to IDLE.

Arbitration in IDLE, in priority order:
- `init_req` has highest priority and is always accepted. It pulses `init_ack`.
- Moves are accepted only when `board_ready` = 1.
- With `STRICT_TURNS` = 1, only `req_valid[turn]` is considered.
- With `STRICT_TURNS` = 0, the turn holder wins; the other requester wins only if the turn holder's `req_valid` is low.

On acceptance:
- The grant pulses `req_grant`.
- The move word is latched into the coordinate and piece output registers.
- A null move (ox==dx and oy==dy) is rejected in the same cycle. `req_grant` still pulses, `error` pulses, the state stays IDLE and the datapath is untouched.

During the operation:
- `initialize_board` or `move_piece` is high for exactly the ISSUE cycle.
- Coordinate and piece outputs are held constant from ISSUE until the return to IDLE. The datapath samples the destination and the origin on different cycles, so they must not change in between.
- Completion pulses are honoured only in the matching WAIT state; completion inputs are ignored in every other state.
- DONE pulses `done`.
- After an init, DONE sets `board_ready` = 1 and sets `turn` = 0.
- After a move, DONE toggles `turn`.

Timeout:
- An expiry in either WAIT state pulses `error`, clears `board_ready` and returns to IDLE.
- After a timeout only `init_req` is accepted.

## Timing
- Reset values: every output is 0 and the state is IDLE. This includes coordinates, piece, `turn` and `board_ready`.
- Requests are sampled at the clk edge while in IDLE.
- The grant or ack pulse coincides with the IDLE→ISSUE transition.
- The datapath start pulse appears the cycle after the grant.
- `done` is asserted the cycle after the complete pulse is sampled.
- Minimum move latency, grant to `done`, is the datapath latency plus 3 cycles.
- Requesters must keep `req_valid` and the move word stable until they see `req_grant`. They must drop `req_valid` the cycle after the grant, otherwise the request is re-served.
- Watchdog counter:
  - Width is 16 bits.
  - It clears on entering WAIT and increments every WAIT cycle.
  - Expiry fires when the count equals `TIMEOUT_CYCLES-1`, with no wrap.
- Simultaneous events:
  - A complete pulse and the expiry in the same cycle count as completion.
  - `init_req` and a move in the same cycle: init wins and the move gets no grant.
- Asynchronous reset mid-operation aborts immediately and forces all outputs to 0. The datapath shares `reset`.

## Configuration
- `BOARD_CTRL_TIMEOUT_EN` defined: the watchdog counter and the timeout path are compiled in.
- `BOARD_CTRL_TIMEOUT_EN` undefined: no counter is built and the WAIT states wait indefinitely. `error` then pulses only on null-move rejection.

## Structure
- Shared package `board_ctrl_pkg` holds:
  - the state encodings (3-bit localparams);
  - the move-word field offsets;
  - the piece codes: empty 0, black 1–6 (pawn, knight, bishop, rook, queen, king), white 7–12 in the same order.
- One sub-module, `op_watchdog`: parameterised counter with clear, enable and expire outputs. It is instantiated only under `BOARD_CTRL_TIMEOUT_EN`.

## Test plan
- Init, then moves:
  - Pulse `init_req` → `init_ack` pulses, then `initialize_board` pulses once.
  - A stubbed `initialize_complete` 300 cycles later → `done` pulses, `board_ready` = 1, `turn` = 0.
- White move: `req0_move` = {7, 4,6, 4,4} → `req_grant` = 01, then `move_piece` pulses with dx=4, dy=4, ox=4, oy=6, piece=7. Outputs stay stable until `done`; `turn` then = 1.
- Turn enforcement (`STRICT_TURNS` = 1, `turn` = 1): `req_valid` = 01 held 20 cycles → no grant. Raising bit 1 → `req_grant` = 10.
- Null move {1, 3,1, 3,1} → `error` pulses and no `move_piece`; `turn` unchanged.
- Timeout (macro on, `TIMEOUT_CYCLES` = 16): withhold `move_complete` → `error` 16 cycles after WAIT entry and `board_ready` = 0. A subsequent move request gets no grant until a new init completes.
- Reset assertion during MOVE_WAIT → all outputs 0 asynchronously and the state is IDLE. A late `move_complete` after reset causes no `done`.
